// File: rtl/code_entry_pkg.sv
// Event codes, FSM state encoding and the fixed-priority pick shared by the
// code-entry front end.
package code_entry_pkg;

    localparam logic [1:0] EV_TOP   = 2'b00;
    localparam logic [1:0] EV_DOWN  = 2'b01;
    localparam logic [1:0] EV_LEFT  = 2'b10;
    localparam logic [1:0] EV_RIGHT = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ENTRY  = 2'b01,
        ST_CHECK  = 2'b10,
        ST_LOCKED = 2'b11
    } state_e;

    // Bit 0 is Top, bit 3 is Right; the lowest set bit wins.
    function automatic logic [1:0] prio_code(input logic [3:0] pend);
        logic [1:0] code;
        if (pend[0]) begin
            code = EV_TOP;
        end else if (pend[1]) begin
            code = EV_DOWN;
        end else if (pend[2]) begin
            code = EV_LEFT;
        end else begin
            code = EV_RIGHT;
        end
        return code;
    endfunction

endpackage

// File: rtl/button_debounce.sv
// One push button: two-flop synchroniser, stability counter and a one-cycle
// press pulse on the rising edge of the debounced level.
module button_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 32'd4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic raw_i,
    output logic press_o
);

    localparam int unsigned CW = (DEBOUNCE_CYCLES > 32'd1) ? $clog2(DEBOUNCE_CYCLES) : 32'd1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 32'd1);

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q;
    logic          level_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          flip_s;

    // The current sample is the last of the required run, so the level flips now.
    assign flip_s  = (sync2_q != level_q) && (cnt_q == CNT_LAST);
    assign press_o = flip_s & sync2_q;

    // Stability counter: any sample equal to the level restarts the run.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        if (sync2_q == level_q) begin
            cnt_d = {CW{1'b0}};
        end else if (flip_s) begin
            cnt_d   = {CW{1'b0}};
            level_d = sync2_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Synchroniser, counter and debounced level registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= {CW{1'b0}};
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/code_entry_arbiter.sv
// Button front end for the code detector: debounced press events serialised by
// priority, attempt sequencing with inter-press timeout, failure count and lockout.
module code_entry_arbiter
    import code_entry_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 32'd4,
    parameter int unsigned TIMEOUT_CYCLES  = 32'd64,
    parameter int unsigned MAX_FAILS       = 32'd3,
    parameter int unsigned LOCKOUT_CYCLES  = 32'd256
) (
    input  logic       clk,
    input  logic       buttonReset,
    input  logic       buttonTop,
    input  logic       buttonDown,
    input  logic       buttonLeft,
    input  logic       buttonRight,
    input  logic       det_ready,
    input  logic       det_done,
    input  logic       det_match,
    output logic       ev_valid,
    output logic [1:0] ev_code,
    output logic       seq_clear,
    output logic       locked,
    output logic [1:0] fail_count
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
    localparam int unsigned LW = $clog2(LOCKOUT_CYCLES);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 32'd1);
    localparam logic [LW-1:0] LOCK_LAST = LW'(LOCKOUT_CYCLES - 32'd1);
    localparam logic [1:0]    FAIL_MAX  = 2'(MAX_FAILS);

    state_e        state_q, state_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [LW-1:0] lock_q, lock_d;
    logic [1:0]    fail_q, fail_d, fail_inc_s;
    logic          match_q, match_d;
    logic [3:0]    pending_q, pending_d;
    logic          ev_valid_q, seq_clear_q, locked_q;
    logic [1:0]    ev_code_q, ev_code_d;
    logic          clear_d;
    logic          grant_s;
    logic [1:0]    gcode_s;
    logic [3:0]    raw_s, press_s;

    assign raw_s = {buttonRight, buttonLeft, buttonDown, buttonTop};

    for (genvar gi = 0; gi < 4; gi++) begin : g_btn
        button_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk_i  (clk),
            .rst_i  (buttonReset),
            .raw_i  (raw_s[gi]),
            .press_o(press_s[gi])
        );
    end

    // Arbitration, attempt sequencing and counters.
    always_comb begin
        state_d    = state_q;
        tmo_d      = tmo_q;
        lock_d     = lock_q;
        fail_d     = fail_q;
        match_d    = match_q;
        clear_d    = 1'b0;
        fail_inc_s = (fail_q == FAIL_MAX) ? fail_q : fail_q + 2'd1;
        grant_s    = ((state_q == ST_IDLE) || (state_q == ST_ENTRY)) && det_ready
                     && (pending_q != 4'b0000);
        gcode_s    = prio_code(pending_q);
        ev_code_d  = grant_s ? gcode_s : ev_code_q;
        // A press landing on the bit being granted survives as a new pending press.
        pending_d  = (pending_q & ~(grant_s ? (4'b0001 << gcode_s) : 4'b0000)) | press_s;
        case (state_q)
            ST_IDLE: begin
                if (grant_s) begin
                    state_d = ST_ENTRY;
                    tmo_d   = {TW{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ENTRY: begin
                if (det_done) begin
                    state_d = ST_CHECK;
                    match_d = det_match;
                end else if (grant_s) begin
                    tmo_d = {TW{1'b0}};
                end else if (tmo_q == TMO_LAST) begin
                    clear_d = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            ST_CHECK: begin
                if (match_q) begin
                    fail_d  = 2'd0;
                    clear_d = 1'b1;
                    state_d = ST_IDLE;
                end else if (fail_inc_s == FAIL_MAX) begin
                    fail_d  = fail_inc_s;
                    lock_d  = {LW{1'b0}};
                    state_d = ST_LOCKED;
                end else begin
                    fail_d  = fail_inc_s;
                    clear_d = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_LOCKED: begin
                pending_d = 4'b0000;
                if (lock_q == LOCK_LAST) begin
                    clear_d = 1'b1;
                    fail_d  = 2'd0;
                    state_d = ST_IDLE;
                end else begin
                    lock_d = lock_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge buttonReset) begin
        if (buttonReset) begin
            state_q     <= ST_IDLE;
            tmo_q       <= {TW{1'b0}};
            lock_q      <= {LW{1'b0}};
            fail_q      <= 2'd0;
            match_q     <= 1'b0;
            pending_q   <= 4'b0000;
            ev_valid_q  <= 1'b0;
            ev_code_q   <= EV_TOP;
            seq_clear_q <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            tmo_q       <= tmo_d;
            lock_q      <= lock_d;
            fail_q      <= fail_d;
            match_q     <= match_d;
            pending_q   <= pending_d;
            ev_valid_q  <= grant_s;
            ev_code_q   <= ev_code_d;
            seq_clear_q <= clear_d;
            locked_q    <= (state_d == ST_LOCKED);
        end
    end

    assign ev_valid   = ev_valid_q;
    assign ev_code    = ev_code_q;
    assign seq_clear  = seq_clear_q;
    assign locked     = locked_q;
    assign fail_count = fail_q;

endmodule

// File: doc/code_entry_arbiter.md
# code_entry_arbiter

Front-end controller between the four push buttons and the code-detector datapath. It synchronises and debounces each button and converts presses into single-cycle events. Simultaneous presses are serialised by fixed priority. The block also sequences attempts: it clears the detector after each attempt or an inter-press timeout, counts failed attempts, and locks out entry after repeated failures.

## Interface
- `DEBOUNCE_CYCLES`, 4: consecutive stable synchronised samples required to change a debounced level.
- `TIMEOUT_CYCLES`, 64: maximum idle cycles between presses inside an attempt.
- `MAX_FAILS`, 3: failed attempts that trigger lockout.
- `LOCKOUT_CYCLES`, 256: lockout duration.

- `clk` in 1: system clock, rising edge.
- `buttonReset` in 1: asynchronous, active-high reset.
- `buttonTop`, `buttonDown`, `buttonLeft`, `buttonRight` in 1 each: raw asynchronous button levels.
- `det_ready` in 1: detector can accept an event this cycle.
- `det_done` in 1: detector has consumed a full code; single-cycle pulse.
- `det_match` in 1: detector verdict, valid only while `det_done`=1.
- `ev_valid` out 1: one-cycle press event to the detector.
- `ev_code` out 2: event code: 00 Top, 01 Down, 10 Left, 11 Right.
- `seq_clear` out 1: one-cycle pulse that clears the detector sequence.
- `locked` out 1: high in LOCKED.
- `fail_count` out 2: failed attempts since the last success or lockout expiry.

## Operation
- **Per-button front end**
  - Two-flop synchroniser feeds a debounce counter.
  - The debounced level changes only after `DEBOUNCE_CYCLES` consecutive equal samples differing from it.
  - A rising edge of the debounced level sets that button's pending bit.
  - Release has no effect.
- **Arbitration**
  - Priority: Top > Down > Left > Right.
  - At most one grant per cycle.
  - Grant conditions: state IDLE or ENTRY, `det_ready`=1, and at least one pending bit set.
  - A grant registers `ev_valid`=1 and `ev_code`, and clears the granted pending bit.
  - Ungranted bits are held.
  - A re-press of an already-pending button merges into that pending bit; no second event is produced.
- **FSM states: IDLE, ENTRY, CHECK, LOCKED**
  - **IDLE**: a grant moves to ENTRY.
  - **ENTRY**
    - Each grant reloads the timeout counter to 0.
    - When the counter reaches `TIMEOUT_CYCLES`-1: pulse `seq_clear`, go to IDLE, `fail_count` unchanged.
    - `det_done`=1 moves to CHECK and latches `det_match`.
    - Grants are still allowed in the same cycle as `det_done`.
  - **CHECK** (one cycle)
    - Match: `fail_count`←0, pulse `seq_clear`, go to IDLE.
    - Mismatch: `fail_count`+1. If the new value equals `MAX_FAILS`, go to LOCKED. Otherwise pulse `seq_clear` and go to IDLE.
    - No grants in CHECK; pending bits are held.
  - **LOCKED**
    - `locked`=1.
    - All pending bits are cleared every cycle, so presses are discarded; no grants.
    - The lockout counter runs from 0. At `LOCKOUT_CYCLES`-1: pulse `seq_clear`, `fail_count`←0, go to IDLE.
- **Reset** (asynchronous)
  - State IDLE; all counters, synchronisers, debounced levels and pending bits 0.
  - Outputs: `ev_valid`=0, `ev_code`=00, `seq_clear`=0, `locked`=0, `fail_count`=0.
  - Reset mid-attempt or mid-lockout abandons it. No `seq_clear` is issued, because the detector shares the same reset.
- `fail_count` saturates at `MAX_FAILS`; its width is 2 bits, so `MAX_FAILS` ≤ 3.

## Timing
- Raw button rises before edge N and then stays stable. The pending bit is set after edge N+1+`DEBOUNCE_CYCLES`. `ev_valid` is high the cycle after edge N+2+`DEBOUNCE_CYCLES`, provided nothing of higher priority is pending and `det_ready`=1.
- `ev_valid` and `seq_clear` are registered outputs, high for exactly one cycle, never both in the same cycle.
- `det_done` at edge M → CHECK during cycle M+1 → `seq_clear` or `locked` visible after edge M+2.
- `det_ready`=0 stalls grants indefinitely without losing pending bits. The timeout counter keeps running.

## Structure
- Package `code_entry_pkg`:
  - event-code constants `EV_TOP`/`EV_DOWN`/`EV_LEFT`/`EV_RIGHT`;
  - FSM state encoding.
- Sub-module `button_debounce` (synchroniser, debounce counter, rising-edge pulse), instantiated four times. The arbiter, FSM and counters live in the top module.

## Test plan
- Press Top, Left, Left, Right, 20 cycles apart, with `det_ready`=1 → `ev_code` 00, 10, 10, 11, each `ev_valid` 7 cycles after its press. Then `det_done`+`det_match` → `seq_clear` pulse, `fail_count`=0.
- Top and Right rise in the same cycle → events 00 then 11 on consecutive cycles.
- A 2-cycle glitch on Down → no event. A 3-cycle high after a 1-cycle low dip → exactly one event.
- Three mismatching `det_done` pulses → `fail_count` 1, 2, then `locked`=1. Presses during lockout produce nothing. After 256 cycles: `locked`=0, `seq_clear` pulse, `fail_count`=0.
- One press, then 64 idle cycles → `seq_clear`, state IDLE, `fail_count` unchanged.
- Assert `buttonReset` mid-lockout, with no clock edge → `locked`=0 and `fail_count`=0 immediately.
